// File: rtl/seg_display_ctrl_if.sv
// Bus between the CPU-side I/O ports and the seven-segment controller.
// master drives load/ch_data and observes status and segments; slave is the controller.
interface seg_display_ctrl_if #(
    parameter int unsigned NCH    = 3,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 2
) ();
    logic                      load;
    logic [NCH*WIDTH-1:0]      ch_data;
    logic                      busy;
    logic                      done;
    logic [NCH*DIGITS*7-1:0]   hex;

    modport master (output load, output ch_data, input busy, input done, input hex);
    modport slave  (input load, input ch_data, output busy, output done, output hex);
endinterface

// File: rtl/seg_display_ctrl.sv
// Multi-channel seven-segment display controller.
// Samples NCH unsigned channels on load, converts each to DIGITS decimal digits with a
// sequential shift-and-add-3 engine, then updates all segment outputs in one cycle.
// Optional macro SEG_LEAD_BLANK_EN: blank leading zero digits (digit 0 always shown).
module seg_display_ctrl #(
    parameter int unsigned NCH    = 3,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 2
) (
    input  logic              clock,
    input  logic              resetn,
    seg_display_ctrl_if.slave bus
);
    // BCD digits needed to hold any WIDTH-bit value, and padded width covering DIGITS too
    localparam int unsigned BD = (WIDTH + 2) / 3;
    localparam int unsigned PD = (BD > DIGITS) ? BD : DIGITS;
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned NW = $clog2(WIDTH + 1);
    localparam int unsigned HW = NCH * DIGITS * 7;

    localparam logic [CW-1:0] LastIdx  = CW'(NCH - 1);
    localparam logic [NW-1:0] LastBit  = NW'(WIDTH - 1);
    localparam logic [6:0]    SegZero  = 7'b1000000;
    localparam logic [6:0]    SegBlank = 7'b1111111;
    localparam logic [6:0]    SegDash  = 7'b0111111;

`ifdef SEG_LEAD_BLANK_EN
    localparam bit LeadBlank = 1'b1;
`else
    localparam bit LeadBlank = 1'b0;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SegBlank;
        endcase
    endfunction

    // Encoding of value 0 on every channel under the active configuration
    function automatic logic [HW-1:0] hex_reset();
        logic [HW-1:0] h;
        h = '0;
        for (int i = 0; i < NCH * DIGITS; i++) begin
            h[i*7 +: 7] = (LeadBlank && (i % DIGITS) != 0) ? SegBlank : SegZero;
        end
        return h;
    endfunction

    localparam logic [HW-1:0] HexRst = hex_reset();

    typedef enum logic [1:0] {StIdle, StShift, StWrite, StCommit} state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [NCH*WIDTH-1:0]   sample_q;
    logic [HW-1:0]          pending_q;
    logic [HW-1:0]          hex_q;
    logic [BD*4-1:0]        bcd_q;
    logic [WIDTH-1:0]       value_q;
    logic [CW-1:0]          ch_idx_q;
    logic [NW-1:0]          cnt_q;

    logic [BD*4-1:0]        bcd_adj;
    logic [BD*4-1:0]        bcd_shift;
    logic [PD*4-1:0]        bcd_pad;
    logic                   overflow;
    logic                   nonzero_seen;
    logic [3:0]             dig;
    logic [DIGITS*7-1:0]    chan_codes;
    logic [HW-1:0]          pending_next;
    logic [CW-1:0]          next_idx;
    logic [WIDTH-1:0]       next_value;

    // Double-dabble step, digit encoding of the finished channel and next-channel fetch
    always_comb begin
        bcd_adj      = bcd_q;
        bcd_pad      = '0;
        overflow     = 1'b0;
        nonzero_seen = 1'b0;
        dig          = 4'd0;
        chan_codes   = '0;
        next_value   = '0;

        for (int i = 0; i < BD; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BD*4-2:0], value_q[WIDTH-1]};

        bcd_pad[BD*4-1:0] = bcd_q;
        for (int d = 0; d < PD; d++) begin
            if (d >= DIGITS && bcd_pad[d*4 +: 4] != 4'd0) overflow = 1'b1;
        end
        // Scan from the top digit so leading zeros are known before they are encoded
        for (int d = DIGITS - 1; d >= 0; d--) begin
            dig = bcd_pad[d*4 +: 4];
            if (dig != 4'd0) nonzero_seen = 1'b1;
            if (overflow) begin
                chan_codes[d*7 +: 7] = SegDash;
            end else if (LeadBlank && !nonzero_seen && d != 0) begin
                chan_codes[d*7 +: 7] = SegBlank;
            end else begin
                chan_codes[d*7 +: 7] = seg7(dig);
            end
        end

        pending_next = pending_q;
        pending_next[ch_idx_q*DIGITS*7 +: DIGITS*7] = chan_codes;

        next_idx = ch_idx_q + 1'b1;
        if (ch_idx_q != LastIdx) next_value = sample_q[next_idx*WIDTH +: WIDTH];
    end

    // Conversion FSM with registered outputs; hex loads on entry to COMMIT so all
    // channels change together in the cycle done is high
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sample_q  <= '0;
            pending_q <= '0;
            hex_q     <= HexRst;
            bcd_q     <= '0;
            value_q   <= '0;
            ch_idx_q  <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StCommit: begin
                    if (bus.load) begin
                        sample_q <= bus.ch_data;
                        value_q  <= bus.ch_data[WIDTH-1:0];
                        bcd_q    <= '0;
                        ch_idx_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StShift;
                    end else begin
                        state_q  <= StIdle;
                    end
                end
                StShift: begin
                    bcd_q   <= bcd_shift;
                    value_q <= value_q << 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) state_q <= StWrite;
                end
                StWrite: begin
                    pending_q <= pending_next;
                    if (ch_idx_q == LastIdx) begin
                        hex_q   <= pending_next;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StCommit;
                    end else begin
                        ch_idx_q <= next_idx;
                        value_q  <= next_value;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= StShift;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hex  = hex_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl (default parameters NCH=3, WIDTH=8, DIGITS=2).
module tb_seg_display_ctrl;
    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int DIG = 2;
    localparam int HW  = NCH * DIG * 7;
    localparam int LAT = NCH * (W + 1) + 1;

    localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000, S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111, SD = 7'b0111111;
`ifdef SEG_LEAD_BLANK_EN
    localparam bit LB = 1'b1;
    localparam logic [6:0] SLEAD = SB;
`else
    localparam bit LB = 1'b0;
    localparam logic [6:0] SLEAD = S0;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [HW-1:0] sb[$];

    always #5 clock = ~clock;

    seg_display_ctrl_if #(.NCH(NCH), .WIDTH(W), .DIGITS(DIG)) bus ();
    seg_display_ctrl #(.NCH(NCH), .WIDTH(W), .DIGITS(DIG)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Reference encoding using integer division rather than shift-and-add
    function automatic logic [HW-1:0] model(input logic [NCH*W-1:0] d);
        logic [HW-1:0] h;
        int v;
        int p;
        h = '0;
        for (int c = 0; c < NCH; c++) begin
            v = int'(d[c*W +: W]);
            for (int k = 0; k < DIG; k++) begin
                p = 10 ** k;
                if (v >= 10 ** DIG)            h[(c*DIG+k)*7 +: 7] = SD;
                else if (LB && k > 0 && v < p) h[(c*DIG+k)*7 +: 7] = SB;
                else                           h[(c*DIG+k)*7 +: 7] = seg((v / p) % 10);
            end
        end
        return h;
    endfunction

    function automatic logic [NCH*W-1:0] pk(input int a, input int b, input int c);
        return {W'(c), W'(b), W'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call at a negedge; returns at the first negedge after the load edge (cycle 1)
    task automatic start(input logic [NCH*W-1:0] d, input logic [HW-1:0] exp, input bit push);
        bus.load = 1'b1;
        bus.ch_data = d;
        if (push) sb.push_back(exp);
        @(negedge clock);
        bus.load = 1'b0;
    endtask

    // From cycle k0, step negedges until done; lat is the cycle done was seen, or -1
    task automatic wait_done(input int k0, output int lat);
        lat = -1;
        for (int k = k0; k <= 80; k++) begin
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic score(input string name);
        if (sb.size() == 0) chk({name, "_sb_empty"}, 64'd1, 64'd0);
        else chk(name, 64'(bus.hex), 64'(sb.pop_front()));
    endtask

    typedef struct {
        logic [NCH*W-1:0] data;
        logic [HW-1:0]    exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat;
        logic [HW-1:0] lit;
        vecs[0] = '{pk(42, 7, 99),    model(pk(42, 7, 99))};
        vecs[1] = '{pk(100, 255, 0),  model(pk(100, 255, 0))};
        vecs[2] = '{pk(12, 34, 56),   model(pk(12, 34, 56))};
        vecs[3] = '{pk(0, 0, 0),      model(pk(0, 0, 0))};
        vecs[4] = '{pk(9, 10, 19),    model(pk(9, 10, 19))};
        vecs[5] = '{pk(255, 99, 100), model(pk(255, 99, 100))};
        vecs[6] = '{pk(1, 200, 50),   model(pk(1, 200, 50))};

        bus.load = 1'b0;
        bus.ch_data = '0;
        repeat (3) @(negedge clock);
        chk("reset_hex", 64'(bus.hex), 64'(model('0)));
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        resetn = 1'b1;
        @(negedge clock);

        // Literal segment codes for the first vector
        lit = {S9, S9, SLEAD, S7, S4, S2};
        start(pk(42, 7, 99), lit, 1'b1);
        chk("lit_busy_c1", 64'(bus.busy), 64'd1);
        wait_done(1, lat);
        chk("lit_latency", 64'(lat), 64'(LAT));
        score("lit_hex");
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            start(vecs[i].data, vecs[i].exp, 1'b1);
            chk($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd1);
            wait_done(1, lat);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
            score($sformatf("vec%0d_hex", i));
            @(negedge clock);
            chk($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
            chk($sformatf("vec%0d_idle", i), 64'(bus.busy), 64'd0);
        end
        chk("dash_literal", 64'(vecs[1].exp[27:0]), 64'({SD, SD, SD, SD}));

        // Load during busy is ignored and not queued
        start(pk(12, 34, 56), model(pk(12, 34, 56)), 1'b1);
        repeat (9) @(negedge clock);
        bus.load = 1'b1;
        bus.ch_data = pk(1, 1, 1);
        @(negedge clock);
        bus.load = 1'b0;
        wait_done(11, lat);
        chk("ign_lat", 64'(lat), 64'(LAT));
        score("ign_hex");
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) lat++;
        end
        chk("ign_no_second", 64'(lat), 64'd0);

        // Reset mid-conversion
        start(pk(77, 88, 99), model(pk(77, 88, 99)), 1'b0);
        repeat (14) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1) lat++;
        end
        chk("rst_no_done", 64'(lat), 64'd0);
        chk("rst_hex", 64'(bus.hex), 64'(model('0)));
        chk("rst_busy", 64'(bus.busy), 64'd0);

        // Load held high: back-to-back conversions, new data sampled in COMMIT
        bus.load = 1'b1;
        bus.ch_data = pk(5, 60, 123);
        sb.push_back(model(pk(5, 60, 123)));
        @(negedge clock);
        wait_done(1, lat);
        chk("b2b_first_lat", 64'(lat), 64'(LAT));
        for (int r = 0; r < 3; r++) begin
            score($sformatf("b2b%0d_hex", r));
            bus.ch_data = pk(r * 30 + 3, 99 - r, 250 - r * 100);
            if (r < 2) sb.push_back(model(bus.ch_data));
            else bus.load = 1'b0;
            if (r < 2) begin
                @(negedge clock);
                wait_done(1, lat);
                chk($sformatf("b2b%0d_period", r), 64'(lat), 64'(LAT));
            end
        end
        @(negedge clock);
        chk("b2b_stop_busy", 64'(bus.busy), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
